// File: rtl/acc_seq_pkg.sv
// Shared op codes and sequencer state encoding for the accumulator and its sequencer.
package acc_seq_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] A_INC   = 3'd1;
    localparam logic [2:0] A_DEC   = 3'd2;
    localparam logic [2:0] A_SHL   = 3'd3;
    localparam logic [2:0] A_SHR   = 3'd4;
    localparam logic [2:0] A_NOT   = 3'd5;
    localparam logic [2:0] A_COM   = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_LOADING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/acc_seq.sv
// Command sequencer for the accumulator: repeats an op N times, issues loads,
// tracks carries and reports completion.
module acc_seq
    import acc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [3:0]        cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              abort,
    output logic              load,
    output logic [2:0]        a_op,
    output logic [DATA_W-1:0] bus_out,
    input  logic              flag_c_in,
    output logic              flag_c_out,
    output logic              busy,
    output logic              done,
    output logic              carry_seen
);

    logic [1:0] state;
    logic [3:0] remaining;
    logic       accept;

    assign cmd_ready = (state == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // Carry is handed straight back so NOP cycles keep it alive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_c_out <= 1'b0;
        else        flag_c_out <= flag_c_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_op       <= OP_NOP;
            load       <= 1'b0;
            bus_out    <= '0;
            carry_seen <= 1'b0;
            remaining  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        carry_seen <= 1'b0;
                        case (cmd_op)
                            OP_NOP: state <= ST_DONE;
                            OP_LOAD: begin
                                load    <= 1'b1;
                                bus_out <= cmd_data;
                                state   <= ST_LOADING;
                            end
                            default: begin
                                a_op      <= cmd_op;
                                remaining <= cmd_count;
                                state     <= ST_ISSUE;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    // Abort leaves carry_seen with whatever it had gathered so far.
                    if (abort) begin
                        a_op  <= OP_NOP;
                        state <= ST_IDLE;
                    end else begin
                        carry_seen <= carry_seen | flag_c_in;
                        if (remaining == 4'd0) begin
                            a_op  <= OP_NOP;
                            state <= ST_DONE;
                        end else begin
                            remaining <= remaining - 4'd1;
                        end
                    end
                end
                ST_LOADING: begin
                    load  <= 1'b0;
                    state <= abort ? ST_IDLE : ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: negedge accumulator model, scoreboard of per-command results.
module tb_acc_seq;
    import acc_seq_pkg::*;

    typedef struct {
        logic [15:0] acc;
        logic        cs;
        int          nops;
        int          nload;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [3:0]  cmd_count = 4'd0;
    logic [15:0] cmd_data = 16'd0;
    logic        abort = 1'b0;
    logic        load;
    logic [2:0]  a_op;
    logic [15:0] bus_out;
    logic        flag_c_in;
    logic        flag_c_out;
    logic        busy;
    logic        done;
    logic        carry_seen;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc = -10;
    exp_t sb[$];

    logic [15:0] acc = 16'd0;
    logic        acc_c = 1'b0;
    logic [15:0] ref_acc = 16'd0;
    logic        ref_c = 1'b0;

    acc_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .abort(abort),
        .load(load), .a_op(a_op), .bus_out(bus_out), .flag_c_in(flag_c_in),
        .flag_c_out(flag_c_out), .busy(busy), .done(done), .carry_seen(carry_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] step(input logic [2:0] op, input logic [15:0] a, input logic c);
        logic [16:0] r;
        case (op)
            A_INC: r = {1'b0, a} + 17'd1;
            A_DEC: r = {1'b0, a} - 17'd1;
            A_SHL: r = {a[15], a[14:0], 1'b0};
            A_SHR: r = {a[0], 1'b0, a[15:1]};
            A_NOT: r = {c, ~a};
            A_COM: r = {c, ~a + 16'd1};
            default: r = {c, a};
        endcase
        return r;
    endfunction

    // Accumulator model samples the sequencer outputs on the falling edge.
    always @(negedge clk) begin
        if (load) acc <= bus_out;
        else {acc_c, acc} <= step(a_op, acc, acc_c);
    end
    assign flag_c_in = acc_c;

    // Scoreboard monitor: pops one expectation per done pulse.
    initial begin
        int n_aop = 0;
        int n_ld = 0;
        bit ovl = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!busy) begin
                    n_aop = 0; n_ld = 0; ovl = 0;
                end else begin
                    if (a_op != 3'd0) n_aop++;
                    if (load) n_ld++;
                    if (load && a_op != 3'd0) ovl = 1;
                    total++;
                    if (cmd_ready) begin
                        bad++;
                        $display("FAIL ready_while_busy: cmd_ready=%b required 0 at cycle %0d", cmd_ready, cyc);
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        if (acc !== e.acc || carry_seen !== e.cs || n_aop != e.nops ||
                            n_ld != e.nload || ovl) begin
                            bad++;
                            $display("FAIL sb_result: acc=%h cs=%b aop_cyc=%0d ld_cyc=%0d ovl=%0d required acc=%h cs=%b aop_cyc=%0d ld_cyc=%0d ovl=0",
                                     acc, carry_seen, n_aop, n_ld, ovl, e.acc, e.cs, e.nops, e.nload);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] cnt, input logic [15:0] data,
                        input bit push, output int acc_cyc);
        exp_t e;
        bit got = 0;
        logic cs;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data;
        for (int i = 0; i < 200 && !got; i++) begin
            if (i > 0) @(negedge clk);
            if (cmd_ready) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout: op=%0d not accepted", op);
            cmd_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc;
        if (push) begin
            if (op == OP_LOAD) begin
                ref_acc = data;
                e = '{data, 1'b0, 0, 1};
            end else if (op == OP_NOP) begin
                e = '{ref_acc, 1'b0, 0, 0};
            end else begin
                cs = 1'b0;
                for (int i = 0; i <= int'(cnt); i++) begin
                    {ref_c, ref_acc} = step(op, ref_acc, ref_c);
                    cs = cs | ref_c;
                end
                e = '{ref_acc, cs, int'(cnt) + 1, 0};
            end
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle_wait();
        bit ok = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({load, a_op, bus_out, flag_c_out, busy, done, carry_seen} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: load=%b a_op=%0d bus=%h c=%b busy=%b done=%b cs=%b required all 0",
                     load, a_op, bus_out, flag_c_out, busy, done, carry_seen);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_inc();
        int ac;
        send(OP_LOAD, 4'd0, 16'hFFFE, 1, ac);
        idle_wait();
        send(A_INC, 4'd2, 16'd0, 1, ac);
        idle_wait();
        total++;
        if (acc !== 16'h0001 || carry_seen !== 1'b1) begin
            bad++; $display("FAIL inc_wrap: acc=%h cs=%b required acc=0001 cs=1", acc, carry_seen);
        end
    endtask

    task automatic test_load_shl();
        int ac;
        send(OP_LOAD, 4'd5, 16'h8001, 1, ac);
        idle_wait();
        total++;
        if (bus_out !== 16'h8001 || load !== 1'b0) begin
            bad++; $display("FAIL load_hold: bus=%h load=%b required bus=8001 load=0", bus_out, load);
        end
        send(A_SHL, 4'd0, 16'h1234, 1, ac);
        idle_wait();
        total++;
        if (acc !== 16'h0002 || carry_seen !== 1'b1 || bus_out !== 16'h8001) begin
            bad++; $display("FAIL shl: acc=%h cs=%b bus=%h required acc=0002 cs=1 bus=8001", acc, carry_seen, bus_out);
        end
    endtask

    task automatic test_nop();
        int ac;
        send(OP_NOP, 4'd3, 16'd0, 1, ac);
        idle_wait();
        total++;
        if (flag_c_out !== 1'b1 || carry_seen !== 1'b0 || acc !== 16'h0002) begin
            bad++; $display("FAIL nop_keep: c_out=%b cs=%b acc=%h required c_out=1 cs=0 acc=0002", flag_c_out, carry_seen, acc);
        end
    endtask

    task automatic test_shr();
        int ac;
        int nb = 0;
        int nhi = 0;
        send(OP_LOAD, 4'd0, 16'hFFFF, 1, ac);
        idle_wait();
        send(A_SHR, 4'd15, 16'd0, 1, ac);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!busy) break;
            nb++;
            if (cmd_ready) nhi++;
        end
        total++;
        if (nb != 17 || nhi != 0) begin
            bad++; $display("FAIL shr_busy: busy_cyc=%0d ready_hi=%0d required 17 and 0", nb, nhi);
        end
        total++;
        if (acc !== 16'h0000 || carry_seen !== 1'b1) begin
            bad++; $display("FAIL shr_result: acc=%h cs=%b required acc=0000 cs=1", acc, carry_seen);
        end
    endtask

    task automatic test_abort();
        int ac;
        bit saw_done = 0;
        send(OP_LOAD, 4'd0, 16'h0010, 1, ac);
        idle_wait();
        send(A_DEC, 4'd9, 16'd0, 0, ac);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk);
        total++;
        if (a_op !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL abort_stop: a_op=%0d busy=%b done=%b rdy=%b required 0 0 0 0", a_op, busy, done, cmd_ready);
        end
        abort = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL abort_ready: cmd_ready=%b required 1", cmd_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        total++;
        if (saw_done || acc !== 16'h000D) begin
            bad++; $display("FAIL abort_nodone: done_seen=%0d acc=%h required 0 and 000d", saw_done, acc);
        end
        ref_acc = acc; ref_c = acc_c;
    endtask

    task automatic test_reset_mid();
        int ac;
        int nz = 0;
        send(A_INC, 4'd5, 16'd0, 1, ac);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({load, a_op, bus_out, flag_c_out, busy, done, carry_seen} !== 23'd0) begin
            bad++;
            $display("FAIL reset_mid: load=%b a_op=%0d bus=%h c=%b busy=%b done=%b cs=%b required all 0",
                     load, a_op, bus_out, flag_c_out, busy, done, carry_seen);
        end
        sb.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_op !== 3'd0 || busy !== 1'b0) nz++;
        end
        total++;
        if (nz != 0 || acc !== 16'h000F) begin
            bad++; $display("FAIL reset_release: active_cyc=%0d acc=%h required 0 and 000f", nz, acc);
        end
        ref_acc = acc; ref_c = acc_c;
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        send(A_INC, 4'd1, 16'd0, 1, a1);
        send(A_DEC, 4'd0, 16'd0, 1, a2);
        total++;
        if (a2 != done_cyc + 1) begin
            bad++; $display("FAIL b2b_second: accept_cyc=%0d required %0d", a2, done_cyc + 1);
        end
        send(A_COM, 4'd0, 16'd0, 1, a3);
        total++;
        if (a3 != done_cyc + 1) begin
            bad++; $display("FAIL b2b_third: accept_cyc=%0d required %0d", a3, done_cyc + 1);
        end
        send(A_NOT, 4'd2, 16'd0, 1, a1);
        idle_wait();
        total++;
        if (sb.size() != 0 || acc !== 16'h000F) begin
            bad++; $display("FAIL b2b_drain: pending=%0d acc=%h required 0 and 000f", sb.size(), acc);
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_load_shl();
        test_nop();
        test_shr();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge (the accumulator it drives samples on falling edge, giving half-cycle setup).
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid, input, 1, command offered.
REQ-004 SHALL have port cmd_ready, output, 1, sequencer can accept a command.
REQ-005 SHALL have port cmd_op, input, 3, 0 NOP, 1 INC, 2 DEC, 3 SHL, 4 SHR, 5 NOT, 6 COM, 7 LOAD.
REQ-006 SHALL have port cmd_count, input, 4, repeat count minus one (0..15 gives 1..16 steps); ignored for LOAD.
REQ-007 SHALL have port cmd_data, input, 16, load value for LOAD.
REQ-008 SHALL have port abort, input, 1, cancel a running command.
REQ-009 SHALL have port load, output, 1, accumulator load strobe.
REQ-010 SHALL have port a_op, output, 3, accumulator op code (codes 1..6 as cmd_op, 0 = hold).
REQ-011 SHALL have port bus_out, output, 16, data presented to accumulator bus input.
REQ-012 SHALL have port flag_c_in, input, 1, carry returned from accumulator.
REQ-013 SHALL have port flag_c_out, output, 1, carry supplied to accumulator; equals last sampled flag_c_in.
REQ-014 SHALL have ports busy (1, output, command in progress), done (1, output, one-cycle completion pulse), carry_seen (1, output, sticky OR of carries during last command).

Function
REQ-015 SHALL implement states IDLE, ISSUE, LOADING, DONE; cmd_ready = (state==IDLE) and not abort.
REQ-016 SHALL accept a command on a rising edge with cmd_valid and cmd_ready both high, and register cmd_op/cmd_count/cmd_data there.
REQ-017 SHALL, on accept of op 1..6, set a_op = cmd_op, remaining = cmd_count, clear carry_seen, enter ISSUE.
REQ-018 SHALL in ISSUE, each rising edge: OR flag_c_in into carry_seen; if remaining==0 set a_op=0 and enter DONE, else decrement remaining; a_op thus held exactly cmd_count+1 cycles.
REQ-019 SHALL, on accept of LOAD, set load=1 and bus_out=cmd_data for exactly one cycle, enter LOADING, then DONE; carry_seen cleared.
REQ-020 SHALL, on accept of NOP, enter DONE directly with a_op=0 and carry_seen cleared.
REQ-021 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy high in ISSUE, LOADING, DONE.
REQ-022 SHALL, on abort high at a rising edge in ISSUE or LOADING, force a_op=0, load=0, enter IDLE, no done pulse; carry_seen keeps its partial value.
REQ-023 SHALL ignore abort in IDLE and DONE except for blocking acceptance in IDLE.
REQ-024 SHALL sample flag_c_in into flag_c_out every rising edge, so NOP cycles preserve carry.
REQ-025 SHALL keep bus_out at last loaded value when load is low; never drive load and nonzero a_op in the same cycle.

Reset
REQ-026 SHALL on rst_n low, asynchronously: state=IDLE, a_op=0, load=0, bus_out=0, flag_c_out=0, busy=0, done=0, carry_seen=0, remaining=0.
REQ-027 SHALL, on reset asserted mid-command, drop a_op/load within the reset assertion and accept no command until rst_n released and first rising edge passes.

Structure
REQ-028 SHALL take op-code constants (A_INC..A_COM, LOAD, NOP) and the state encoding from a shared package used also by the accumulator.
REQ-029 SHALL be a single module with no sub-modules; a 4-bit down counter is internal.

Verification
REQ-030 SHALL cover INC, count=2 with accumulator preloaded 0xFFFE: a_op=1 for 3 cycles -> accumulator 0x0001, carry_seen=1, done once.
REQ-031 SHALL cover LOAD cmd_data=0x8001 then SHL count=0: load one cycle, accumulator 0x0002, carry_seen=1.
REQ-032 SHALL cover SHR count=15 on 0xFFFF: 16 a_op cycles -> accumulator 0x0000, carry_seen=1, cmd_ready low throughout.
REQ-033 SHALL cover abort in 3rd cycle of DEC count=9: a_op=0 next cycle, no done, cmd_ready high the following cycle.
REQ-034 SHALL cover rst_n low mid-ISSUE: all outputs zero immediately, a_op stays 0 after release until new command.
REQ-035 SHALL cover cmd_valid held with back-to-back commands: second accepted on first IDLE cycle after done, never during busy.
